// File: rtl/r2r_dac_wavegen_pkg.sv
// Shared types and waveform lookup for the R2R DAC sample generator.
// Build with R2R_WAVEGEN_SINE_LUT_EN to back mode 3 with a sine ROM; otherwise mode 3 aliases to saw.
package r2r_dac_pkg;

  localparam int DAC_W   = 4;
  localparam int PHASE_W = 5;

  typedef enum logic [1:0] {
    MODE_SAW = 2'd0,
    MODE_TRI = 2'd1,
    MODE_SQR = 2'd2,
    MODE_SIN = 2'd3
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

`ifdef R2R_WAVEGEN_SINE_LUT_EN
  // Offset-binary sine, midscale 8; entry 31 is listed first.
  localparam logic [31:0][DAC_W-1:0] SINE_ROM = {
    4'd6,  4'd5,  4'd4,  4'd3,  4'd2,  4'd1,  4'd1,  4'd0,
    4'd1,  4'd1,  4'd2,  4'd3,  4'd4,  4'd5,  4'd6,  4'd8,
    4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15, 4'd15, 4'd15,
    4'd15, 4'd15, 4'd14, 4'd13, 4'd12, 4'd11, 4'd10, 4'd8
  };
`endif

  function automatic logic [DAC_W-1:0] wave_code(input mode_e mode,
                                                 input logic [PHASE_W-1:0] phase);
    logic [DAC_W-1:0] code;
    code = phase[DAC_W-1:0];
    case (mode)
      MODE_TRI: code = phase[4] ? ~phase[3:0] : phase[3:0];
      MODE_SQR: code = phase[4] ? 4'hF : 4'h0;
`ifdef R2R_WAVEGEN_SINE_LUT_EN
      MODE_SIN: code = SINE_ROM[phase];
`endif
      default:  code = phase[DAC_W-1:0];
    endcase
    return code;
  endfunction

endpackage

// File: rtl/r2r_dac_wavegen_if.sv
// Control and sample bus between the waveform generator and its controller/DAC stage.
interface r2r_dac_wavegen_if;
  import r2r_dac_pkg::*;

  logic             enable;
  logic [1:0]       mode;
  logic [7:0]       divider;
  logic             set_divider;
  logic [DAC_W-1:0] sample;
  logic             sample_valid;
  logic             running;

  modport master (
    output enable, mode, divider, set_divider,
    input  sample, sample_valid, running
  );

  modport slave (
    input  enable, mode, divider, set_divider,
    output sample, sample_valid, running
  );

endinterface

// File: rtl/r2r_dac_prescaler.sv
// Tick prescaler: holds the divider and counts it down, pulsing tick when the count hits zero.
// Tick is combinational from the count; a divider load while running restarts the period with no tick.
module r2r_dac_prescaler #(
  parameter logic [7:0] DIV_RESET = 8'd0
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       load,
  input  logic [7:0] divider,
  input  logic       restart,
  input  logic       run,
  output logic       tick
);

  logic [7:0] div_q;
  logic [7:0] presc;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      div_q <= DIV_RESET;
      presc <= 8'd0;
    end else begin
      if (load) div_q <= divider;
      if (restart) begin
        presc <= div_q;
      end else if (run) begin
        if (load)                presc <= divider;
        else if (presc == 8'd0)  presc <= div_q;
        else                     presc <= presc - 8'd1;
      end
    end
  end

  assign tick = run && !load && (presc == 8'd0);

endmodule

// File: rtl/r2r_dac_wavegen.sv
// 4-bit waveform generator (saw/triangle/square, sine with R2R_WAVEGEN_SINE_LUT_EN) for the R2R DAC.
// First sample 2+div cycles after enable is seen, then one every div+1; no backpressure, valid is a strobe.
module r2r_dac_wavegen
  import r2r_dac_pkg::*;
#(
  parameter logic [7:0] DIV_RESET = 8'd0
) (
  input  logic              clk,
  input  logic              n_rst,
  r2r_dac_wavegen_if.slave  bus
);

  state_e               state, state_nxt;
  logic [PHASE_W-1:0]   phase, phase_nxt;
  mode_e                mode_q, mode_q_nxt;
  logic [DAC_W-1:0]     sample_nxt;
  logic                 valid_nxt;
  logic                 restart;
  logic                 run;
  logic                 tick;

  // Enable low wins over the divider load and the tick, so the counter freezes.
  assign restart = (state == ST_IDLE) && bus.enable;
  assign run     = (state == ST_RUN)  && bus.enable;

  r2r_dac_prescaler #(
    .DIV_RESET (DIV_RESET)
  ) u_presc (
    .clk     (clk),
    .n_rst   (n_rst),
    .load    (bus.set_divider),
    .divider (bus.divider),
    .restart (restart),
    .run     (run),
    .tick    (tick)
  );

  always_comb begin
    state_nxt  = state;
    phase_nxt  = phase;
    mode_q_nxt = mode_q;
    sample_nxt = bus.sample;
    valid_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.enable) begin
          state_nxt  = ST_RUN;
          phase_nxt  = '0;
          mode_q_nxt = mode_e'(bus.mode);
        end
      end
      ST_RUN: begin
        if (!bus.enable) begin
          state_nxt = ST_IDLE;
        end else if (tick) begin
          sample_nxt = wave_code(mode_q, phase);
          phase_nxt  = phase + 1'b1;
          valid_nxt  = 1'b1;
          mode_q_nxt = mode_e'(bus.mode);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state            <= ST_IDLE;
      phase            <= '0;
      mode_q           <= MODE_SAW;
      bus.sample       <= '0;
      bus.sample_valid <= 1'b0;
      bus.running      <= 1'b0;
    end else begin
      state            <= state_nxt;
      phase            <= phase_nxt;
      mode_q           <= mode_q_nxt;
      bus.sample       <= sample_nxt;
      bus.sample_valid <= valid_nxt;
      bus.running      <= (state_nxt == ST_RUN);
    end
  end

endmodule

// File: tb/tb_r2r_dac_wavegen.sv
// Directed bench for r2r_dac_wavegen: expected codes and arrival cycles are queued at stimulus time
// and matched against every sample_valid strobe.
module tb_r2r_dac_wavegen;

  typedef struct {
    logic [3:0] code;
    int         at;
  } exp_t;

  logic clk;
  logic n_rst;
  int   cyc;
  int   vectors;
  int   miscompares;
  exp_t sb [$];
  exp_t e;

  int sine_tbl [32] = '{8, 10, 11, 12, 13, 14, 15, 15, 15, 15, 15, 14, 13, 12, 11, 10,
                        8, 6, 5, 4, 3, 2, 1, 1, 0, 1, 1, 2, 3, 4, 5, 6};

  r2r_dac_wavegen_if bus ();

  r2r_dac_wavegen #(
    .DIV_RESET (8'd0)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Waveform reference written from the code tables, indexed by tick number.
  function automatic logic [3:0] ref_code(input int m, input int i);
    int p;
    int r;
    p = i % 32;
    case (m)
      1:       r = (p < 16) ? p : 31 - p;
      2:       r = (p < 16) ? 0 : 15;
`ifdef R2R_WAVEGEN_SINE_LUT_EN
      3:       r = sine_tbl[p];
`endif
      default: r = p % 16;
    endcase
    return r[3:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic goto(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [3:0] code, input int at);
    exp_t x;
    x.code = code;
    x.at   = at;
    sb.push_back(x);
  endtask

  task automatic set_div(input int d);
    bus.set_divider = 1'b1;
    bus.divider     = 8'(d);
    goto(cyc + 1);
    bus.set_divider = 1'b0;
  endtask

  // Runs n ticks, then drops enable so it is seen on what would be the next tick edge.
  task automatic run_seq(input int d, input int m, input int n, input string tag);
    int e0;
    int last;
    bus.mode   = 2'(m);
    bus.enable = 1'b1;
    e0 = cyc;
    for (int i = 0; i < n; i++) push(ref_code(m, i), e0 + 2 + d + i * (d + 1));
    last = e0 + 2 + d + (n - 1) * (d + 1);
    goto(last + d);
    bus.enable = 1'b0;
    goto(cyc + 3);
    check({tag, "_drained"}, sb.size(), 0);
    check({tag, "_frozen_sample"}, bus.sample, ref_code(m, n - 1));
    check({tag, "_running_low"}, bus.running, 0);
  endtask

  always @(negedge clk) begin
    if (n_rst && bus.sample_valid) begin
      vectors++;
      assert (sb.size() != 0) else begin
        miscompares++;
        $error("FAIL unexpected_valid: sample %0d at cycle %0d with nothing expected", bus.sample, cyc);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        vectors++;
        assert (bus.sample === e.code) else begin
          miscompares++;
          $error("FAIL sample_code: observed %0d expected %0d (cycle %0d)", bus.sample, e.code, cyc);
        end
        vectors++;
        assert (cyc === e.at) else begin
          miscompares++;
          $error("FAIL valid_cycle: observed %0d expected %0d", cyc, e.at);
        end
      end
    end
  end

  initial begin
    int e0;
    vectors         = 0;
    miscompares     = 0;
    n_rst           = 1'b0;
    bus.enable      = 1'b0;
    bus.mode        = 2'd0;
    bus.divider     = 8'd0;
    bus.set_divider = 1'b0;

    goto(3);
    check("reset_sample", bus.sample, 0);
    check("reset_valid", bus.sample_valid, 0);
    check("reset_running", bus.running, 0);
    n_rst = 1'b1;
    goto(cyc + 1);

    // Saw at divider 3, then a restart from phase 0.
    set_div(3);
    run_seq(3, 0, 20, "saw_div3");
    run_seq(3, 0, 3, "saw_restart");

    // Triangle back to back, one tick past the phase wrap.
    set_div(0);
    run_seq(0, 1, 33, "tri_div0");

    set_div(1);
    run_seq(1, 2, 34, "square_div1");

    set_div(0);
    run_seq(0, 3, 4, "mode3");

    // Divider reload mid-count: next tick 8 cycles after the load edge.
    set_div(3);
    bus.mode   = 2'd0;
    bus.enable = 1'b1;
    e0 = cyc;
    push(4'd0, e0 + 5);
    push(4'd1, e0 + 15);
    push(4'd2, e0 + 23);
    goto(e0 + 6);
    bus.set_divider = 1'b1;
    bus.divider     = 8'd7;
    goto(e0 + 7);
    bus.set_divider = 1'b0;
    check("reload_running", bus.running, 1);
    goto(e0 + 30);
    bus.enable = 1'b0;
    goto(cyc + 3);
    check("reload_drained", sb.size(), 0);
    check("reload_sample", bus.sample, 2);

    // Mode switch to square right after tick 2: tick 3 still saw, tick 4 square.
    set_div(1);
    bus.mode   = 2'd0;
    bus.enable = 1'b1;
    e0 = cyc;
    push(4'd0, e0 + 3);
    push(4'd1, e0 + 5);
    push(4'd2, e0 + 7);
    push(4'd3, e0 + 9);
    push(4'd0, e0 + 11);
    push(4'd0, e0 + 13);
    goto(e0 + 7);
    bus.mode = 2'd2;
    goto(e0 + 14);
    bus.enable = 1'b0;
    goto(cyc + 3);
    check("modechg_drained", sb.size(), 0);

    // Asynchronous reset between clock edges.
    set_div(3);
    bus.mode   = 2'd0;
    bus.enable = 1'b1;
    e0 = cyc;
    push(4'd0, e0 + 5);
    push(4'd1, e0 + 9);
    goto(e0 + 11);
    #2;
    check("pre_reset_sample", bus.sample, 1);
    check("pre_reset_running", bus.running, 1);
    n_rst = 1'b0;
    #1;
    check("async_reset_sample", bus.sample, 0);
    check("async_reset_running", bus.running, 0);
    check("async_reset_valid", bus.sample_valid, 0);
    bus.enable = 1'b0;
    goto(cyc + 2);
    n_rst = 1'b1;
    goto(cyc + 3);
    check("final_drained", sb.size(), 0);
    check("final_running", bus.running, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/r2r_dac_wavegen.md
Name: r2r_dac_wavegen

Overview:
- Upstream sample source for the 4-bit R2R DAC drive stage.
- Generates a 4-bit waveform code (sawtooth, triangle, square, optional sine) at a programmable rate.
- Presents each new code on `sample` with a one-cycle `sample_valid` strobe.
- The downstream DAC control registers `sample` onto the R2R drive bits.

Parameters:
- DIV_RESET, 8'd0: divider value held after reset.
- PHASE_W, 5: phase accumulator width. Fixed at 5; one waveform period is 32 ticks.

Ports:
- clk  input  1  system clock, all logic on rising edge
- n_rst  input  1  reset, asynchronous, active-low
- enable  input  1  level; high runs the generator, low idles it
- mode  input  2  0 = saw, 1 = triangle, 2 = square, 3 = sine (see Optional Feature)
- divider  input  8  tick period minus one, in clk cycles
- set_divider  input  1  one-cycle strobe that loads `divider`
- sample  output  4  current DAC code
- sample_valid  output  1  one-cycle pulse when `sample` updates
- running  output  1  high while in the RUN state

Behaviour:
- Reset is async assert and sync release. Reset values:
  - state = IDLE
  - div_q = DIV_RESET
  - presc = 0
  - phase = 0
  - mode_q = 0
  - sample = 4'd0
  - sample_valid = 0
  - running = 0
- Divider load: `set_divider` high loads div_q <= divider in any state.
  - If in RUN on the same edge, presc <= divider; the new period starts immediately and no tick occurs on that edge.
- State machine:
  - IDLE:
    - sample holds its last value; sample_valid = 0.
    - If enable = 1: go to RUN, presc <= div_q, phase <= 0, mode_q <= mode.
  - RUN:
    - enable = 0 takes priority over a tick: go to IDLE; phase, presc and sample freeze; no valid pulse.
    - Otherwise, if presc == 0, a tick occurs:
      - presc <= div_q
      - sample <= f(mode_q, phase)
      - phase <= phase + 1, wrapping 31 -> 0
      - sample_valid <= 1
      - mode_q <= mode; a mode change therefore takes effect from the sample after next.
    - Otherwise presc <= presc - 1 and sample_valid <= 0.
- Timing: the enable rising edge is sampled at edge k.
  - The first sample_valid is seen after edge k+1+div_q, carrying f(mode, 0).
  - After that, one pulse every div_q+1 cycles.
  - div_q = 0 gives a valid pulse every cycle.
- Waveform f(m, p), with p the 5-bit phase:
  - saw: p[3:0]. Period 16 ticks, repeated twice per phase wrap.
  - triangle: p[4] ? ~p[3:0] : p[3:0]. Sequence 0..15, then 15..0; the peak and trough values are each held for 2 ticks.
  - square: p[4] ? 4'hF : 4'h0.
  - sine: see Optional Feature.
- `running` equals (state == RUN), registered.
- Simultaneous events, in priority order: n_rst, then enable falling, then set_divider, then tick.
- Reset asserted mid-operation: outputs return to their reset values immediately (asynchronously).

Optional Feature:
- Macro: R2R_WAVEGEN_SINE_LUT_EN.
- Defined: mode 3 reads a 32-entry, 4-bit sine ROM indexed by p, offset-binary with midscale 8. Table:
  8,10,11,12,13,14,15,15,15,15,15,14,13,12,11,10,8,6,5,4,3,2,1,1,0,1,1,2,3,4,5,6
- Undefined: mode 3 aliases to saw; no ROM is instantiated.

Decomposition:
- Package r2r_dac_pkg holds:
  - mode constants MODE_SAW, MODE_TRI, MODE_SQR, MODE_SIN
  - DAC_W = 4, PHASE_W = 5
  - function wave_code(mode, phase), with the sine ROM inside a SINE_LUT_EN guard
- One sub-module, r2r_dac_prescaler. It owns div_q and presc, takes load / restart / run inputs, and outputs `tick`.
- The FSM and phase logic stay in the top module.

Test Plan:
- Reset, then set_divider with divider = 3, then enable, mode = saw:
  - First sample_valid 5 cycles after enable is sampled, sample = 0.
  - Then pulses every 4 cycles with codes 1, 2, ..., 15, 0, ... (wrapping).
- Triangle, divider = 0: 32 consecutive valid samples equal 0..15, 15..0; phase wraps cleanly back to 0.
- Square, divider = 1: sample is 0 for 16 ticks, then 15 for 16 ticks; the valid pulse period is 2 cycles.
- Mid-run events:
  - Drop enable on a would-be tick edge: no valid pulse, sample frozen.
  - Re-enable: the sequence restarts at f(0).
  - set_divider = 7 mid-count: the next tick comes exactly 8 cycles later.
- Mode change saw -> square at tick N: sample N+1 is still saw, and square begins at tick N+2.
- Mode 3:
  - With SINE_LUT_EN, the sequence starts 8, 10, 11, 12.
  - Without it, the output matches saw.
  - Assert n_rst low asynchronously mid-run: sample = 0, running = 0 without waiting for a clock edge.
